// File: rtl/ofs_fim_axi_mmio_csr_bridge_if.sv
// AXI4 MMIO bus bundle between the MMIO fabric (master) and the CSR bridge (slave).
// Latency: none, wires only.
// Backpressure: standard AXI4 valid/ready on every channel.
// Ports: aw*/w*/ar* driven by master, b*/r* driven by slave; aw/ar lock/cache/prot/qos carried but unused.
interface ofs_fim_axi_mmio_csr_bridge_if #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 10
);
    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;

    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;

    logic                    rvalid;
    logic                    rready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/ofs_fim_axi_mmio_csr_bridge.sv
// AXI4 MMIO slave -> single-beat CSR port; splits INCR/FIXED bursts, round-robin R/W, SLVERR on bad bursts.
// Latency: csr_wr one cycle after each W beat; csr_rd one cycle after grant/R beat; one transaction in flight.
// Backpressure: ready only in IDLE (aw/ar) and WR_DATA (w); B/R held until bready/rready.
// Ports: clk, rst (sync, active-high); axi (slave modport of ofs_fim_axi_mmio_csr_bridge_if);
//        csr_wr/csr_rd/csr_addr/csr_wdata/csr_wstrb out, csr_rd_valid/csr_rdata in.
// Optional: define OFS_AXI_MMIO_CSR_RD_TIMEOUT_EN to time out CSR reads after RD_TIMEOUT cycles.
module ofs_fim_axi_mmio_csr_bridge #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 10,
    parameter int RD_TIMEOUT = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    ofs_fim_axi_mmio_csr_bridge_if.slave axi,
    output logic                      csr_wr,
    output logic                      csr_rd,
    output logic [ADDR_WIDTH-1:0]     csr_addr,
    output logic [DATA_WIDTH-1:0]     csr_wdata,
    output logic [DATA_WIDTH/8-1:0]   csr_wstrb,
    input  logic                      csr_rd_valid,
    input  logic [DATA_WIDTH-1:0]     csr_rdata
);
    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam int         LSB         = $clog2(STRB_W);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT, RD_DATA} state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic                    prio_rd;     // 0: write wins a simultaneous aw/ar request
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [7:0]              cnt_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    err_q;       // whole-burst error
    logic                    beat_err_q;  // current read beat timed out
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    wr_pend_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;

    logic                    aw_grant;
    logic                    ar_grant;
    logic                    last_beat;
    logic                    tmo_hit;
    logic [ADDR_WIDTH-1:0]   addr_aligned;
    logic [ADDR_WIDTH-1:0]   addr_next;

    // Bursts the CSR port cannot express: WRAP, reserved, or beats wider than the bus.
    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
        return ((burst != BURST_FIXED) && (burst != BURST_INCR)) || (int'(size) > LSB);
    endfunction

    assign last_beat    = (cnt_q == len_q);
    assign addr_aligned = {addr_q[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
    assign addr_next    = (burst_q == BURST_INCR) ? addr_q + (ADDR_WIDTH'(1) << size_q) : addr_q;

`ifdef OFS_AXI_MMIO_CSR_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(RD_TIMEOUT);
    logic [TMO_W-1:0] tmo_q;

    // tmo_q counts cycles since csr_rd, so a hit at RD_TIMEOUT-1 puts rvalid RD_TIMEOUT cycles after it.
    assign tmo_hit = (tmo_q == TMO_W'(RD_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (state == RD_REQ) begin
            tmo_q <= TMO_W'(1);
        end else if (state == RD_WAIT) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    localparam int unused_rd_timeout = RD_TIMEOUT;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        aw_grant    = 1'b0;
        ar_grant    = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.rvalid  = 1'b0;
        csr_rd      = 1'b0;
        case (state)
            IDLE: begin
                aw_grant = axi.awvalid & (~axi.arvalid | ~prio_rd);
                ar_grant = axi.arvalid & (~axi.awvalid |  prio_rd);
                if (aw_grant) begin
                    state_nxt = WR_DATA;
                end else if (ar_grant) begin
                    state_nxt = RD_REQ;
                end
            end
            WR_DATA: begin
                axi.wready = 1'b1;
                if (axi.wvalid && last_beat) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                axi.bvalid = 1'b1;
                if (axi.bready) begin
                    state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                csr_rd    = ~err_q;
                state_nxt = err_q ? RD_DATA : RD_WAIT;
            end
            RD_WAIT: begin
                if (csr_rd_valid || tmo_hit) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                axi.rvalid = 1'b1;
                if (axi.rready) begin
                    state_nxt = last_beat ? IDLE : RD_REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign axi.awready = aw_grant;
    assign axi.arready = ar_grant;
    assign axi.bid     = id_q;
    assign axi.bresp   = ((state == WR_RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi.rid     = id_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = ((state == RD_DATA) && (err_q || beat_err_q)) ? RESP_SLVERR : RESP_OKAY;
    assign axi.rlast   = (state == RD_DATA) && last_beat;

    // Write beats are registered, so csr_addr shows the captured beat address while csr_wr is up.
    assign csr_wr    = wr_pend_q & ~err_q;
    assign csr_addr  = wr_pend_q ? wr_addr_q : addr_aligned;
    assign csr_wdata = wdata_q;
    assign csr_wstrb = wstrb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_rd    <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            beat_err_q <= 1'b0;
            rdata_q    <= '0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            wr_pend_q <= 1'b0;

            if (aw_grant) begin
                id_q       <= axi.awid;
                addr_q     <= axi.awaddr;
                len_q      <= axi.awlen;
                size_q     <= axi.awsize;
                burst_q    <= axi.awburst;
                cnt_q      <= '0;
                err_q      <= burst_err(axi.awburst, axi.awsize);
                beat_err_q <= 1'b0;
                prio_rd    <= 1'b1;
            end else if (ar_grant) begin
                id_q       <= axi.arid;
                addr_q     <= axi.araddr;
                len_q      <= axi.arlen;
                size_q     <= axi.arsize;
                burst_q    <= axi.arburst;
                cnt_q      <= '0;
                err_q      <= burst_err(axi.arburst, axi.arsize);
                beat_err_q <= 1'b0;
                prio_rd    <= 1'b0;
            end

            if ((state == WR_DATA) && axi.wvalid) begin
                wr_pend_q <= 1'b1;
                wr_addr_q <= addr_aligned;
                wdata_q   <= axi.wdata;
                wstrb_q   <= axi.wstrb;
                if (axi.wlast != last_beat) begin
                    err_q <= 1'b1;
                end
                if (!last_beat) begin
                    cnt_q  <= cnt_q + 8'd1;
                    addr_q <= addr_next;
                end
            end

            if ((state == RD_REQ) && err_q) begin
                rdata_q    <= '0;
                beat_err_q <= 1'b0;
            end

            // A response arriving on the timeout cycle still wins.
            if (state == RD_WAIT) begin
                if (csr_rd_valid) begin
                    rdata_q    <= csr_rdata;
                    beat_err_q <= 1'b0;
                end else if (tmo_hit) begin
                    rdata_q    <= '0;
                    beat_err_q <= 1'b1;
                end
            end

            if ((state == RD_DATA) && axi.rready && !last_beat) begin
                cnt_q  <= cnt_q + 8'd1;
                addr_q <= addr_next;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{axi.awlock, axi.awcache, axi.awprot, axi.awqos,
                         axi.arlock, axi.arcache, axi.arprot, axi.arqos};
endmodule

// File: tb/tb_ofs_fim_axi_mmio_csr_bridge.sv
// Scoreboard bench for the AXI MMIO CSR bridge: random and directed bursts against a burst-level model.
// Latency: n/a.
// Backpressure: bready/rready toggled randomly; CSR responder answers after 1..4 cycles.
module tb_ofs_fim_axi_mmio_csr_bridge;
    localparam int AW = 21;
    localparam int DW = 64;
    localparam int IW = 10;
    localparam int SW = DW / 8;
    localparam logic [7:0] G_W = 8'h57;
    localparam logic [7:0] G_R = 8'h52;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ofs_fim_axi_mmio_csr_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi();

    logic          csr_wr;
    logic          csr_rd;
    logic [AW-1:0] csr_addr;
    logic [DW-1:0] csr_wdata;
    logic [SW-1:0] csr_wstrb;
    logic          csr_rd_valid;
    logic [DW-1:0] csr_rdata;

    ofs_fim_axi_mmio_csr_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .RD_TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .axi          (axi),
        .csr_wr       (csr_wr),
        .csr_rd       (csr_rd),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_wstrb    (csr_wstrb),
        .csr_rd_valid (csr_rd_valid),
        .csr_rdata    (csr_rdata)
    );

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb; } wr_exp_t;
    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct { logic [DW-1:0] data; int lat; bit drop; } rsp_t;

    wr_exp_t       exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    b_exp_t        exp_b[$];
    r_exp_t        exp_r[$];
    rsp_t          rsp_q[$];
    logic [7:0]    grant_log[$];
    int            wr_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rd_cyc = 0;
    int rv_rise_cyc = 0;
    bit rv_prev = 1'b0;
    bit hold_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference model: burst legality and per-beat CSR address from AXI rules.
    function automatic bit burst_bad(input logic [1:0] burst, input logic [2:0] size);
        return (burst >= 2'd2) || ((1 << size) > SW);
    endfunction

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input logic [2:0] size,
                                                 input logic [1:0] burst, input int i);
        logic [AW-1:0] r;
        r = (burst == 2'b01) ? AW'(int'(a) + i * (1 << size)) : a;
        return r & ~AW'(SW - 1);
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin : monitor
        wr_exp_t we;
        b_exp_t  be;
        r_exp_t  re;
        if (!rst) begin
            if (axi.awvalid && axi.awready) grant_log.push_back(G_W);
            if (axi.arvalid && axi.arready) grant_log.push_back(G_R);
            if (csr_wr) begin
                wr_cyc.push_back(cyc);
                if (exp_wr.size() == 0) begin
                    fail("csr_wr_unexpected", "csr_wr=1, required no write");
                end else begin
                    we = exp_wr.pop_front();
                    check("csr_wr_addr", 128'(csr_addr), 128'(we.addr));
                    check("csr_wdata", 128'(csr_wdata), 128'(we.data));
                    check("csr_wstrb", 128'(csr_wstrb), 128'(we.strb));
                end
            end
            if (axi.bvalid) begin
                if (exp_b.size() == 0) begin
                    fail("bvalid_unexpected", "bvalid=1, required 0");
                end else if (axi.bready) begin
                    be = exp_b.pop_front();
                    check("bid", 128'(axi.bid), 128'(be.id));
                    check("bresp", 128'(axi.bresp), 128'(be.resp));
                end
            end
            if (axi.rvalid && !rv_prev) rv_rise_cyc = cyc;
            if (axi.rvalid) begin
                if (exp_r.size() == 0) begin
                    fail("rvalid_unexpected", "rvalid=1, required 0");
                end else if (axi.rready) begin
                    re = exp_r.pop_front();
                    check("rid", 128'(axi.rid), 128'(re.id));
                    check("rdata", 128'(axi.rdata), 128'(re.data));
                    check("rresp", 128'(axi.rresp), 128'(re.resp));
                    check("rlast", 128'(axi.rlast), 128'(re.last));
                end
            end
        end
        rv_prev = axi.rvalid;
    end

    // CSR read responder
    initial begin : responder
        rsp_t rs;
        csr_rd_valid = 1'b0;
        csr_rdata    = '0;
        forever begin
            @(negedge clk);
            if (!rst && csr_rd) begin
                last_rd_cyc = cyc;
                if (exp_rd.size() == 0) begin
                    fail("csr_rd_unexpected", "csr_rd=1, required no read");
                end else begin
                    check("csr_rd_addr", 128'(csr_addr), 128'(exp_rd.pop_front()));
                end
                if (rsp_q.size() != 0) begin
                    rs = rsp_q.pop_front();
                    if (!rs.drop) begin
                        repeat (rs.lat) @(posedge clk);
                        #1;
                        csr_rd_valid = 1'b1;
                        csr_rdata    = rs.data;
                        @(posedge clk);
                        #1;
                        csr_rd_valid = 1'b0;
                        csr_rdata    = '0;
                    end
                end
            end
        end
    end

    // Random B/R backpressure
    initial begin
        axi.bready = 1'b0;
        axi.rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            axi.bready = !hold_b && ($urandom_range(3) != 0);
            axi.rready = ($urandom_range(3) != 0);
        end
    end

    // n_abort > 0: send only that many beats and expect no response (caller resets).
    task automatic axi_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int max_gap,
                             input int n_abort);
        bit      bad;
        b_exp_t  be;
        wr_exp_t we;
        int      n;
        int      nbeats;
        bad    = burst_bad(burst, size);
        nbeats = (n_abort > 0) ? n_abort : int'(len) + 1;
        if (n_abort == 0) begin
            be.id   = id;
            be.resp = bad ? 2'b10 : 2'b00;
            exp_b.push_back(be);
        end
        axi.awvalid = 1'b1; axi.awid = id; axi.awaddr = addr; axi.awlen = len;
        axi.awsize = size; axi.awburst = burst;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.awready && n < 500);
        if (!axi.awready) fail("aw_timeout", "awready not seen in 500 cycles, required 1");
        @(posedge clk);
        #1 axi.awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            repeat ($urandom_range(max_gap)) begin @(posedge clk); #1; end
            axi.wvalid = 1'b1;
            axi.wdata  = {$urandom, $urandom};
            axi.wstrb  = SW'($urandom);
            axi.wlast  = (i == int'(len));
            if (!bad) begin
                we.addr = beat_addr(addr, size, burst, i);
                we.data = axi.wdata;
                we.strb = axi.wstrb;
                exp_wr.push_back(we);
            end
            n = 0;
            do begin @(negedge clk); n++; end while (!axi.wready && n < 500);
            if (!axi.wready) fail("w_timeout", "wready not seen in 500 cycles, required 1");
            @(posedge clk);
            #1;
            axi.wvalid = 1'b0;
            axi.wlast  = 1'b0;
        end
        if (n_abort == 0) begin
            n = 0;
            while (exp_b.size() != 0 && n < 2000) begin @(posedge clk); n++; end
            #1;
            if (exp_b.size() != 0) fail("b_timeout", "no B response in 2000 cycles, required one");
        end
    endtask

    // lat = 0 picks a random CSR latency; drop removes the CSR response of beat 0.
    task automatic axi_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int lat,
                            input bit drop);
        bit     bad;
        r_exp_t re;
        rsp_t   rs;
        int     n;
        bad = burst_bad(burst, size);
        for (int i = 0; i <= int'(len); i++) begin
            re.id   = id;
            re.last = (i == int'(len));
            if (bad) begin
                re.data = '0;
                re.resp = 2'b10;
            end else begin
                exp_rd.push_back(beat_addr(addr, size, burst, i));
                rs.data = {$urandom, $urandom};
                rs.lat  = (lat != 0) ? lat : int'($urandom_range(1, 4));
                rs.drop = drop && (i == 0);
                rsp_q.push_back(rs);
                re.data = rs.drop ? '0 : rs.data;
                re.resp = rs.drop ? 2'b10 : 2'b00;
            end
            exp_r.push_back(re);
        end
        axi.arvalid = 1'b1; axi.arid = id; axi.araddr = addr; axi.arlen = len;
        axi.arsize = size; axi.arburst = burst;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.arready && n < 2000);
        if (!axi.arready) fail("ar_timeout", "arready not seen in 2000 cycles, required 1");
        @(posedge clk);
        #1 axi.arvalid = 1'b0;
        n = 0;
        while (exp_r.size() != 0 && n < 5000) begin @(posedge clk); n++; end
        #1;
        if (exp_r.size() != 0) fail("r_timeout", "R beats missing after 5000 cycles");
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded 60000 cycles, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin : stim
        logic [AW-1:0] a;
        logic [2:0]    sz;
        logic [1:0]    bu;
        int            k;
        axi.awvalid = 0; axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0;
        axi.awburst = '0; axi.awlock = 0; axi.awcache = '0; axi.awprot = '0; axi.awqos = '0;
        axi.wvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 0;
        axi.arvalid = 0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
        axi.arburst = '0; axi.arlock = 0; axi.arcache = '0; axi.arprot = '0; axi.arqos = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              128'({axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid,
                    csr_wr, csr_rd, axi.bresp, axi.rresp, axi.rlast}), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Simultaneous requests from reset: write first, then strict alternation.
        grant_log.delete();
        for (int r = 0; r < 2; r++) begin
            fork
                axi_write(IW'(10 + r), 21'h500, 8'd1, 3'd3, 2'b01, 0, 0);
                axi_read (IW'(20 + r), 21'h600, 8'd1, 3'd3, 2'b01, 0, 1'b0);
            join
        end
        check("grant_count", 128'(grant_log.size()), 128'(4));
        if (grant_log.size() == 4)
            check("grant_order", 128'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}),
                  128'({G_W, G_R, G_W, G_R}));

        // INCR write, back-to-back beats -> consecutive csr_wr.
        wr_cyc.delete();
        axi_write(IW'(1), 21'h100, 8'd3, 3'd3, 2'b01, 0, 0);
        check("b2b_count", 128'(wr_cyc.size()), 128'(4));
        if (wr_cyc.size() == 4)
            for (int i = 1; i < 4; i++) check("b2b_gap", 128'(wr_cyc[i] - wr_cyc[i-1]), 128'(1));

        // FIXED read, CSR answers after 3 cycles.
        axi_read(IW'(2), 21'h40, 8'd1, 3'd3, 2'b00, 3, 1'b0);

        // Illegal bursts.
        axi_write(IW'(3), 21'h80, 8'd1, 3'd3, 2'b10, 1, 0);
        axi_write(IW'(4), 21'h80, 8'd0, 3'd2, 2'b11, 0, 0);
        axi_read (IW'(5), 21'h88, 8'd0, 3'd4, 2'b01, 0, 1'b0);
        axi_read (IW'(6), 21'h88, 8'd2, 3'd3, 2'b10, 0, 1'b0);

        // Narrow beats and address wrap at the top of the space.
        axi_write(IW'(7), 21'h1FFFF4, 8'd3, 3'd2, 2'b01, 1, 0);
        axi_read (IW'(8), 21'h1FFFF8, 8'd2, 3'd3, 2'b01, 0, 1'b0);

        // Maximum burst length.
        axi_write(IW'(9), 21'h2000, 8'd255, 3'd3, 2'b01, 0, 0);

        // Reset in the middle of a write burst: no B, next burst is normal.
        axi_write(IW'(11), 21'h200, 8'd3, 3'd3, 2'b01, 0, 2);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("reset_wr_drained", 128'(exp_wr.size()), 128'(0));
        axi_write(IW'(12), 21'h200, 8'd3, 3'd3, 2'b01, 1, 0);

        // bready held low keeps bvalid asserted.
        hold_b = 1'b1;
        fork
            axi_write(IW'(13), 21'h300, 8'd0, 3'd3, 2'b01, 0, 0);
            begin
                k = 0;
                do begin @(negedge clk); k++; end while (!axi.bvalid && k < 200);
                if (!axi.bvalid) fail("bvalid_wait", "bvalid not seen in 200 cycles, required 1");
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    check("bvalid_held", 128'(axi.bvalid), 128'(1));
                end
                hold_b = 1'b0;
            end
        join

`ifdef OFS_AXI_MMIO_CSR_RD_TIMEOUT_EN
        axi_read(IW'(14), 21'h700, 8'd0, 3'd3, 2'b01, 0, 1'b1);
        check("timeout_latency", 128'(rv_rise_cyc - last_rd_cyc), 128'(16));
        axi_read(IW'(15), 21'h700, 8'd1, 3'd3, 2'b01, 0, 1'b1);
`endif

        // Randomized mix.
        for (int t = 0; t < 40; t++) begin
            a  = (t % 8 == 0) ? 21'h1FFFF0 : AW'($urandom);
            sz = ($urandom_range(9) == 0) ? 3'd4 : 3'($urandom_range(3));
            k  = $urandom_range(9);
            bu = (k < 6) ? 2'b01 : (k < 9) ? 2'b00 : 2'($urandom_range(2, 3));
            if ($urandom_range(1) == 1)
                axi_write(IW'($urandom), a, 8'($urandom_range(7)), sz, bu, 2, 0);
            else
                axi_read(IW'($urandom), a, 8'($urandom_range(7)), sz, bu, 0, 1'b0);
        end

        repeat (10) @(posedge clk);
        #1;
        check("queues_empty",
              128'(exp_wr.size() + exp_rd.size() + exp_b.size() + exp_r.size() + rsp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
